// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, read-mode enum and width helper for the FIFO family
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 8;
  typedef enum logic {STD, FWFT} fifo_mode_e;
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointers, occupancy count, level flags and sticky error flags
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2,
  parameter int AW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);
  logic ov_set;
  logic uf_set;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    almost_full = count >= CW'(AF_LVL);
    almost_empty = count <= CW'(AE_LVL);
    push = !flush && wr_en && !full;
    pop = !flush && rd_en && !empty;
    ov_set = !flush && wr_en && full;
    uf_set = !flush && rd_en && empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      count <= flush ? '0 : count + CW'(push) - CW'(pop);
      overflow <= ov_set | (overflow & ~clr_err);
      underflow <= uf_set | (underflow & ~clr_err);
    end
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parameterised single-clock FIFO with level flags, sticky errors, flush and optional FWFT read
module fifo_sync_param #(
  parameter int DATA_W = fifo_pkg::DEF_DATA_W,
  parameter int DEPTH = fifo_pkg::DEF_DEPTH,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2,
  parameter int FWFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  import fifo_pkg::*;
  localparam int AW = clog2_safe(DEPTH);
  localparam int CW = AW + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  if (DATA_W < 1 || DATA_W > 32 || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
      AE_LVL >= AF_LVL || AF_LVL > DEPTH) begin : g_bad_cfg
    $fatal(1, "fifo_sync_param: illegal DATA_W/DEPTH/AF_LVL/AE_LVL combination");
  end
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  fifo_ctrl #(
    .DEPTH (DEPTH),
    .AF_LVL(AF_LVL),
    .AE_LVL(AE_LVL),
    .AW    (AW),
    .CW    (CW)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .clr_err     (clr_err),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .push        (push),
    .pop         (pop),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  if (MODE == fifo_pkg::FWFT) begin : g_fwft
    always_comb begin
      rd_data = empty ? '0 : mem[rd_ptr];
      rd_valid = !empty;
    end
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rd_data <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= pop;
        if (pop) rd_data <= mem[rd_ptr];
      end
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: checks standard and FWFT instances against a queue-based reference model
module tb_fifo_sync_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] s_rd;
  logic [7:0] f_rd;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ov, s_uf;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ov, f_uf;
  logic [3:0] s_count;
  logic [3:0] f_count;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_rq = 8'h00;
  logic       m_rv = 1'b0;
  logic       m_ov = 1'b0;
  logic       m_uf = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ov), .underflow(s_uf)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ov), .underflow(f_uf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    check("count", 32'(s_count), 32'(n));
    check("empty", 32'(s_empty), 32'(n == 0));
    check("full", 32'(s_full), 32'(n == 8));
    check("almost_full", 32'(s_af), 32'(n >= 6));
    check("almost_empty", 32'(s_ae), 32'(n <= 2));
    check("overflow", 32'(s_ov), 32'(m_ov));
    check("underflow", 32'(s_uf), 32'(m_uf));
    check("rd_valid", 32'(s_rv), 32'(m_rv));
    check("rd_data", 32'(s_rd), 32'(m_rq));
    check("f_count", 32'(f_count), 32'(n));
    check("f_full", 32'(f_full), 32'(n == 8));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("f_almost_full", 32'(f_af), 32'(n >= 6));
    check("f_almost_empty", 32'(f_ae), 32'(n <= 2));
    check("f_overflow", 32'(f_ov), 32'(m_ov));
    check("f_underflow", 32'(f_uf), 32'(m_uf));
    check("f_rd_valid", 32'(f_rv), 32'(n != 0));
    check("f_rd_data", 32'(f_rd), 32'((n != 0) ? q[0] : 8'h00));
  endtask

  task automatic model_reset();
    q.delete();
    m_rq = 8'h00;
    m_rv = 1'b0;
    m_ov = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic model_step();
    int n = q.size();
    bit ps = !flush && wr_en && n < 8;
    bit pp = !flush && rd_en && n > 0;
    bit ov_set = !flush && wr_en && n == 8;
    bit uf_set = !flush && rd_en && n == 0;
    m_ov = ov_set | (m_ov & !clr_err);
    m_uf = uf_set | (m_uf & !clr_err);
    if (flush) begin
      q.delete();
      m_rv = 1'b0;
    end else begin
      m_rv = pp;
      if (pp) m_rq = q.pop_front();
      if (ps) q.push_back(wr_data);
    end
  endtask

  task automatic cyc(input bit fl, input bit ce, input bit we, input logic [7:0] wd, input bit re);
    flush = fl;
    clr_err = ce;
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 8'(8'h11 + i), 0);
      check("push_count", 32'(s_count), 32'(i + 1));
    end
    check("full_at_8", 32'(s_full), 32'd1);
    cyc(0, 0, 1, 8'hFF, 0);
    check("overflow_9th", 32'(s_ov), 32'd1);
    check("count_stays_8", 32'(s_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 8'h00, 1);
      check("pop_data", 32'(s_rd), 32'(8'h11 + i));
      check("pop_valid", 32'(s_rv), 32'd1);
    end
    check("empty_end", 32'(s_empty), 32'd1);
    cyc(0, 0, 0, 8'h00, 1);
    check("underflow_pop", 32'(s_uf), 32'd1);
    cyc(0, 1, 0, 8'h00, 0);
    check("clr_ov", 32'(s_ov), 32'd0);
    check("clr_uf", 32'(s_uf), 32'd0);
    cyc(0, 1, 0, 8'h00, 1);
    check("set_wins", 32'(s_uf), 32'd1);
    cyc(0, 0, 1, 8'hA5, 0);
    cyc(0, 0, 1, 8'h5A, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 8'(i + 1), 1);
      check("concurrent_count", 32'(s_count), 32'd2);
      check("concurrent_data", 32'(s_rd), 32'((i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : 8'(i - 1)));
    end
    cyc(1, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h3C, 0);
    check("fwft_data", 32'(f_rd), 32'h3C);
    check("fwft_valid", 32'(f_rv), 32'd1);
    cyc(0, 0, 0, 8'h00, 1);
    check("fwft_drained", 32'(f_rv), 32'd0);
    check("fwft_count", 32'(f_count), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'h40 + i), 0);
    cyc(1, 0, 1, 8'h77, 0);
    check("flush_count", 32'(s_count), 32'd0);
    check("flush_empty", 32'(s_empty), 32'd1);
    check("flush_no_ov", 32'(s_ov), 32'd0);
    check("flush_no_uf", 32'(s_uf), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h60 + i), i[0]);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();
    for (int i = 0; i < 600; i++) begin
      int wb = ((i / 40) % 2 == 1) ? 75 : 30;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < 100 - wb);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's fixed 8-bit FIFO.
- Adds configurable width and depth, occupancy count, programmable almost-full and almost-empty flags, and a synchronous flush.
- Adds sticky overflow and underflow error flags and a compile-time standard/first-word-fall-through (FWFT) read mode.
- Sits between the tt_um pad-level wrapper and any producer/consumer logic; the wrapper maps ui_in/uio_in/uo_out onto its ports.

Parameters:
- DATA_W, 8, data word width in bits (1..32).
- DEPTH, 8, number of entries; must be a power of 2, 2..64.
- AF_LVL, 6, almost_full asserts when count >= AF_LVL.
- AE_LVL, 2, almost_empty asserts when count <= AE_LVL.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of contents; errors are retained
- clr_err  input  1  synchronous clear of the sticky error flags
- wr_en  input  1  push request
- wr_data  input  DATA_W  push data
- rd_en  input  1  pop request
- rd_data  output  DATA_W  read data
- rd_valid  output  1  standard mode: rd_data holds a popped word this cycle; FWFT mode: equals !empty
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LVL
- almost_empty  output  1  count <= AE_LVL
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async assert, sync release):
  - pointers and count = 0; empty = 1, almost_empty = 1.
  - full, almost_full, rd_valid, overflow, underflow = 0.
  - rd_data = 0.
  - Memory contents are not reset.
- Storage: register array of DEPTH x DATA_W. Write and read pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Count is a separate register.
- Push: accepted iff wr_en && !full, evaluated on the registered full. Data is written at wr_ptr; wr_ptr increments.
- Pop: accepted iff rd_en && !empty; rd_ptr increments.
- Simultaneous events:
  - Both accepted: count unchanged.
  - Full with both wr_en and rd_en: pop accepted, push rejected, overflow set.
  - Empty with both: push accepted, pop rejected, underflow set.
- Count: +1 on push only, -1 on pop only, otherwise held. All flags are combinational from the registered count.
- Standard mode (FWFT=0):
  - On an accepted pop at edge N, rd_data is loaded with mem[rd_ptr] at edge N and rd_valid = 1 for the cycle after edge N.
  - Otherwise rd_valid = 0 and rd_data holds its last value.
  - Latency: write at edge N, earliest pop request in cycle N+1, data visible after edge N+1.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - A word written at edge N is on rd_data with rd_valid = 1 in the cycle following edge N.
  - rd_en acknowledges and advances to the next word.
- Errors: overflow and underflow set on the rejected request and hold until clr_err or reset. If a set and clr_err coincide in the same cycle, set wins.
- Flush:
  - At the next edge, pointers and count go to 0 and rd_valid goes to 0.
  - Any wr_en or rd_en in the same cycle is ignored and raises no error.
  - Flush takes priority over push and pop.
- Reset mid-operation: state returns to reset values immediately and all contents are discarded.
- Elaboration checks: DEPTH must be a power of 2, AE_LVL < AF_LVL <= DEPTH, else $fatal.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2_safe;
  - localparam defaults for DATA_W and DEPTH;
  - enum fifo_mode_e {STD, FWFT}.
- One sub-module, fifo_ctrl: pointers, count, flags, error logic.
- Top fifo_sync_param instantiates fifo_ctrl plus the storage array and read-data path.

Test Plan (DEPTH=8, DATA_W=8, AF_LVL=6, AE_LVL=2):
1. Reset, then push 0x11..0x18 across 8 cycles.
   - Expected: count steps 1..8; almost_empty drops at count=3; almost_full rises at count=6; full = 1 at 8.
   - A 9th push of 0xFF gives overflow = 1, count stays 8, and data is unchanged.
2. FWFT=0, FIFO full from scenario 1: pop 8 times.
   - Expected: rd_data = 0x11..0x18, each with rd_valid one cycle after its pop; empty = 1 at the end.
   - A further pop gives underflow = 1.
3. Assert clr_err.
   - Expected: overflow and underflow = 0 next cycle.
   - clr_err together with a pop-on-empty leaves underflow = 1 (set wins).
4. Push 0xA5 and 0x5A, then wr_en and rd_en together for 4 cycles with data 0x01..0x04.
   - Expected: count stays 2; reads return 0xA5, 0x5A, 0x01, 0x02.
   - Continue the pointer run past index 7 to exercise wrap; ordering must be preserved.
5. FWFT=1: push 0x3C at edge N.
   - Expected: rd_data = 0x3C and rd_valid = 1 in cycle N+1 with no rd_en.
   - rd_en then gives rd_valid = 0 with count = 0.
6. Three entries stored, flush asserted together with wr_en (0x77):
   - Expected next cycle: count = 0, empty = 1, no overflow or underflow.
   - Separately, rst_n pulsed low mid-stream: all outputs at reset values asynchronously, before the next clock edge.
